column_select_encoder: RTL and testbench

- Input-side counterpart of the attack-column 7-segment decoder. Turns the player's raw NEXT/PREV/FIRE push-buttons into the 3-bit column code A,B,C; that code drives the column decoder directly.
- Issues a valid/ack fire request carrying the chosen column to the game-control logic.
- Sits between the board push-buttons and the game FSM; one per player console.

---
 rtl/column_select_pkg.sv | 10 +
 rtl/column_select_encoder_button_conditioner.sv | 38 +++
 rtl/column_select_encoder.sv | 96 +++++++++
 tb/tb_column_select_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/column_select_pkg.sv
// column_select_pkg: shared state encoding and sizing for the column select encoder.
package column_select_pkg;
  localparam int COL_W = 3;
  localparam int MAX_COLS = 8;
  typedef enum logic [1:0] {
    ST_SELECT  = 2'd0,
    ST_REQUEST = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/column_select_encoder_button_conditioner.sv
// button_conditioner: 2-flop synchronizer, debounce counter and rising-edge press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, level_q, level_d, press_q, press_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (s2_q != level_q) && (cnt_q == LAST);
    cnt_d = (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
    press_d = flip & ~level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/column_select_encoder.sv
// column_select_encoder: debounced NEXT/PREV/FIRE buttons to column code A,B,C and a valid/ack fire request.
// Define COLUMN_SELECT_AUTOREPEAT_EN to step repeatedly while NEXT or PREV is held.
module column_select_encoder
  import column_select_pkg::*;
#(
  parameter int NUM_COLS = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_NEXT,
  input  logic             BTN_PREV,
  input  logic             BTN_FIRE,
  input  logic             FIRE_ACK,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             FIRE_VALID,
  output logic [COL_W-1:0] FIRE_COL,
  output logic             BUSY
);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  logic next_lvl, next_press, prev_lvl, prev_press, fire_lvl, fire_press;
  logic step_next, step_prev;
  state_t state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, fire_col_q, fire_col_d;
  logic fire_valid_q, fire_valid_d;
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(CLK), .rst(RST), .btn_raw(BTN_NEXT), .level(next_lvl), .press(next_press));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk(CLK), .rst(RST), .btn_raw(BTN_PREV), .level(prev_lvl), .press(prev_press));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
    .clk(CLK), .rst(RST), .btn_raw(BTN_FIRE), .level(fire_lvl), .press(fire_press));
`ifdef COLUMN_SELECT_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic hold, rpt;
  // Counter holds cycles since the press (or last repeat); both buttons held means no motion.
  always_comb begin
    hold = (state_q == ST_SELECT) && (next_lvl ^ prev_lvl);
    rpt = hold && (rpt_cnt_q == RW'(REPEAT_CYCLES));
    rpt_cnt_d = !hold ? '0 : rpt ? RW'(1) : rpt_cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) rpt_cnt_q <= RST ? '0 : rpt_cnt_d;
  assign step_next = next_press | (rpt & next_lvl);
  assign step_prev = prev_press | (rpt & prev_lvl);
`else
  logic unused_lvl;
  assign unused_lvl = next_lvl ^ prev_lvl ^ (REPEAT_CYCLES > 0);
  assign step_next = next_press;
  assign step_prev = prev_press;
`endif
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    fire_valid_d = fire_valid_q;
    fire_col_d = fire_col_q;
    case (state_q)
      ST_SELECT:
        if (fire_press) begin
          fire_col_d = col_q;
          fire_valid_d = 1'b1;
          state_d = ST_REQUEST;
        end else if (step_next && !step_prev) begin
          col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        end else if (step_prev && !step_next) begin
          col_d = (col_q == '0) ? LAST_COL : col_q - 1'b1;
        end
      ST_REQUEST:
        if (FIRE_ACK) begin
          fire_valid_d = 1'b0;
          state_d = ST_RELEASE;
        end
      ST_RELEASE: state_d = fire_lvl ? ST_RELEASE : ST_SELECT;
      default: state_d = ST_SELECT;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SELECT;
      col_q <= '0;
      fire_valid_q <= 1'b0;
      fire_col_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      fire_valid_q <= fire_valid_d;
      fire_col_q <= fire_col_d;
    end
  end
  assign {A, B, C} = col_q;
  assign FIRE_VALID = fire_valid_q;
  assign FIRE_COL = fire_col_q;
  assign BUSY = state_q != ST_SELECT;
endmodule

// File: tb/tb_column_select_encoder.sv
// tb_column_select_encoder: directed scenarios plus random button sequences against a press-level model.
module tb_column_select_encoder;
  localparam int D = 4, N = 5, R = 10;
  logic clk = 0, rst = 1, bn = 0, bp = 0, bf = 0, ack = 0;
  logic a, b, c, fv, busy;
  logic [2:0] fc, abc;
  int total = 0, bad = 0;
  int m_col = 0, m_fcol = 0;
  bit m_req = 0;
  always #5 clk = ~clk;
  assign abc = {a, b, c};
  column_select_encoder #(.NUM_COLS(N), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLK(clk), .RST(rst), .BTN_NEXT(bn), .BTN_PREV(bp), .BTN_FIRE(bf), .FIRE_ACK(ack),
    .A(a), .B(b), .C(c), .FIRE_VALID(fv), .FIRE_COL(fc), .BUSY(busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) bn = v;
    else if (which == 1) bp = v;
    else bf = v;
  endtask

  task automatic mdl_press(input int which);
    if (m_req) return;
    if (which == 0) m_col = (m_col + 1) % N;
    else if (which == 1) m_col = (m_col + N - 1) % N;
    else begin
      m_req = 1;
      m_fcol = m_col;
    end
  endtask

  task automatic tap(input int which, input int hold);
    set_btn(which, 1);
    cyc(hold);
    set_btn(which, 0);
    cyc(D + 4);
    if (hold >= D) mdl_press(which);
  endtask

  task automatic do_ack();
    ack = 1;
    cyc(1);
    ack = 0;
    cyc(3);
    m_req = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " col"}, abc, m_col);
    chk({tag, " valid"}, fv, m_req);
    chk({tag, " busy"}, busy, m_req);
    if (m_req) chk({tag, " fire_col"}, fc, m_fcol);
  endtask

  initial begin
    int lat, steps;
    logic [2:0] start;
    cyc(3);
    chk("reset col", abc, 0);
    chk("reset valid", fv, 0);
    chk("reset busy", busy, 0);
    chk("reset fire_col", fc, 0);
    rst = 0;
    cyc(2);
    repeat (3) tap(0, 6);
    chk("three next", abc, 3'b011);
    check_state("three next");
    tap(0, 6);
    tap(0, 6);
    chk("wrap up", abc, 0);
    tap(1, 6);
    chk("wrap down", abc, 4);
    start = abc;
    lat = 0;
    bn = 1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      cyc(1);
      if (k == 6) bn = 0;
      if (abc != start) lat = k;
    end
    bn = 0;
    cyc(D + 4);
    mdl_press(0);
    chk("press latency", lat, 7);
    check_state("after latency");
    tap(0, 3);
    check_state("glitch");
    tap(0, 6);
    tap(0, 6);
    tap(2, 6);
    for (int i = 0; i < 20; i++) begin
      chk("req valid", fv, 1);
      chk("req fire_col", fc, 2);
      cyc(1);
    end
    tap(0, 6);
    tap(0, 6);
    chk("req ignores next", abc, 3'b010);
    check_state("req hold");
    ack = 1;
    cyc(1);
    ack = 0;
    chk("ack drops valid", fv, 0);
    m_req = 0;
    cyc(3);
    check_state("after ack");
    bf = 1;
    cyc(D + 4);
    mdl_press(2);
    check_state("held fire req");
    ack = 1;
    cyc(1);
    ack = 0;
    m_req = 0;
    cyc(20);
    chk("release busy", busy, 1);
    chk("release no refire", fv, 0);
    bf = 0;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      cyc(1);
      if (!busy) lat = k;
    end
    chk("release return", lat, D + 3);
    cyc(3);
    tap(2, 6);
    check_state("refire");
    do_ack();
    tap(1, 6);
    bn = 1;
    bf = 1;
    cyc(6);
    bn = 0;
    bf = 0;
    cyc(D + 4);
    mdl_press(2);
    chk("next+fire col", abc, 1);
    chk("next+fire fire_col", fc, 1);
    check_state("next+fire");
    do_ack();
    bn = 1;
    bp = 1;
    cyc(6);
    bn = 0;
    bp = 0;
    cyc(D + 4);
    chk("next+prev", abc, 1);
    tap(0, 6);
    tap(0, 6);
    tap(2, 6);
    check_state("pre reset req");
    rst = 1;
    cyc(1);
    rst = 0;
    m_col = 0;
    m_req = 0;
    chk("mid-req reset col", abc, 0);
    chk("mid-req reset valid", fv, 0);
    chk("mid-req reset busy", busy, 0);
    cyc(2);
`ifdef COLUMN_SELECT_AUTOREPEAT_EN
    steps = 4;
`else
    steps = 1;
`endif
    bn = 1;
    cyc(35);
    bn = 0;
    cyc(D + 4);
    m_col = steps % N;
    chk("autorepeat steps", abc, m_col);
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op <= 2) tap(op, $urandom_range(D, 9));
      else if (op == 3) do_ack();
      else if (op == 4) tap($urandom_range(0, 2), $urandom_range(1, D - 1));
      else tap(0, $urandom_range(D, 9));
      check_state("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
